// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit with HI/LO result registers.
//
// Operations (MDop, qualified by start while idle):
//   000 MULT   signed 32x32 -> 64 product in {HI,LO}, 5 busy cycles
//   001 MULTU  unsigned 32x32 -> 64 product in {HI,LO}, 5 busy cycles
//   010 DIV    signed divide, LO = quotient, HI = remainder, 10 busy cycles
//   011 DIVU   unsigned divide, LO = quotient, HI = remainder, 10 busy cycles
//   100 MTHI   HI <= srcA immediately, never busy
//   101 MTLO   LO <= srcA immediately, never busy
//   11x        no operation
//
// Configuration macro: MDU_DIV_EN
//   defined   -> divider compiled in (DIV/DIVU as above)
//   undefined -> no divider logic; DIV/DIVU behave as no-ops
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   srcA   operand A (dividend / multiplicand / MTHI-MTLO data)
//   srcB   operand B (divisor / multiplier)
//   MDop   operation select
//   start  qualifies MDop for one cycle
//   busy   high while a multi-cycle operation is in progress
//   HI, LO result registers
//
// All outputs come straight from flops; operands are captured at acceptance
// so later srcA/srcB changes cannot disturb an operation in flight.
// -----------------------------------------------------------------------------
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  MDop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // Counter start values: busy lasts (value + 1) cycles.
    localparam logic [3:0] MUL_CNT = 4'd4;
`ifdef MDU_DIV_EN
    localparam logic [3:0] DIV_CNT = 4'd9;
`endif

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [2:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;

    logic [63:0] res_s;
    logic        wr_s;

    // 64-bit product; operands are sign- or zero-extended so the low 64 bits
    // of the product are exact for both signed and unsigned forms.
    function automatic logic [63:0] mul_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

`ifdef MDU_DIV_EN
    // Returns {remainder, quotient}. The divisor is replaced by 1 when it is
    // zero (result discarded by the caller) and for 0x80000000 / -1, where
    // dividing by 1 yields exactly the required quotient 0x80000000, rem 0.
    function automatic logic [63:0] div_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [31:0]        d;
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic [31:0]        q;
        logic [31:0]        r;
        if ((b == 32'd0) || (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) begin
            d = 32'd1;
        end else begin
            d = b;
        end
        if (sgn) begin
            sa = a;
            sd = d;
            q  = sa / sd;
            r  = sa % sd;
        end else begin
            q  = a / d;
            r  = a % d;
        end
        return {r, q};
    endfunction
`endif

    // Result of the operation in flight, computed from the latched operands.
    always_comb begin
        res_s = 64'd0;
        wr_s  = 1'b0;
        case (op_r)
            OP_MULT: begin
                res_s = mul_f(a_r, b_r, 1'b1);
                wr_s  = 1'b1;
            end
            OP_MULTU: begin
                res_s = mul_f(a_r, b_r, 1'b0);
                wr_s  = 1'b1;
            end
`ifdef MDU_DIV_EN
            OP_DIV: begin
                res_s = div_f(a_r, b_r, 1'b1);
                wr_s  = (b_r != 32'd0);
            end
            OP_DIVU: begin
                res_s = div_f(a_r, b_r, 1'b0);
                wr_s  = (b_r != 32'd0);
            end
`endif
            default: begin
                res_s = 64'd0;
                wr_s  = 1'b0;
            end
        endcase
    end

    // Control FSM, operand capture and HI/LO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        case (MDop)
                            OP_MULT, OP_MULTU: begin
                                op_r    <= MDop;
                                a_r     <= srcA;
                                b_r     <= srcB;
                                cnt_r   <= MUL_CNT;
                                busy_r  <= 1'b1;
                                state_r <= BUSY;
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                op_r    <= MDop;
                                a_r     <= srcA;
                                b_r     <= srcB;
                                cnt_r   <= DIV_CNT;
                                busy_r  <= 1'b1;
                                state_r <= BUSY;
                            end
`endif
                            OP_MTHI: hi_r <= srcA;
                            OP_MTLO: lo_r <= srcA;
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                BUSY: begin
                    // Start requests are ignored here; the final edge
                    // deasserts busy and commits the result together.
                    if (cnt_r == 4'd0) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                        if (wr_s) begin
                            hi_r <= res_s[63:32];
                            lo_r <= res_s[31:0];
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port srcA, input, 32, operand A (dividend / multiplicand / MTHI-MTLO data), same source as the ALU srcA.
REQ-004 SHALL have port srcB, input, 32, operand B (divisor / multiplier), same source as the ALU srcB.
REQ-005 SHALL have port MDop, input, 3, operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x none.
REQ-006 SHALL have port start, input, 1, qualifies MDop for one cycle.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port HI, output, 32, HI register.
REQ-009 SHALL have port LO, output, 32, LO register.

Function
REQ-010 SHALL implement two states, IDLE and BUSY, with a 4-bit cycle counter.
REQ-011 SHALL, in IDLE, accept start=1 with MDop in {MULT, MULTU} at edge T, latch operands, enter BUSY, and hold busy=1 for exactly 5 cycles (T+1..T+5).
REQ-012 SHALL, in IDLE, accept start=1 with MDop in {DIV, DIVU} at edge T, enter BUSY, and hold busy=1 for exactly 10 cycles (T+1..T+10).
REQ-013 SHALL update HI/LO on the same edge that deasserts busy; new values SHALL be visible in the first cycle with busy=0.
REQ-014 SHALL keep HI/LO at their previous values throughout BUSY.
REQ-015 SHALL, for MULT/MULTU, produce the 64-bit signed/unsigned product, {HI,LO} = srcA*srcB.
REQ-016 SHALL, for DIV, set LO = quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-017 SHALL, for DIVU, set LO = unsigned quotient and HI = unsigned remainder.
REQ-018 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, set LO = 0x80000000 and HI = 0.
REQ-019 SHALL, for divisor 0 (DIV or DIVU), run the full 10 busy cycles and leave HI/LO unchanged.
REQ-020 SHALL, for MTHI/MTLO with start=1 in IDLE, write srcA to HI/LO at that edge with no busy assertion.
REQ-021 SHALL ignore start (any MDop) while busy=1; operands latched at acceptance SHALL be used regardless of later srcA/srcB changes.
REQ-022 SHALL ignore start with MDop 11x (no state change).
REQ-023 SHALL allow a new start in the first cycle with busy=0 (back-to-back operations, no dead cycle).
REQ-024 SHALL be purely a function of latched state for outputs (no combinational path from inputs to busy/HI/LO).

Reset
REQ-025 SHALL, on reset low, immediately force state IDLE, busy=0, HI=0, LO=0, counter=0, independent of clk.
REQ-026 SHALL, on reset asserted mid-operation, abort the operation with no HI/LO update after release.
REQ-027 SHALL accept a start on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL use macro MDU_DIV_EN to compile the divider in or out.
REQ-029 SHALL, with MDU_DIV_EN defined, implement REQ-012 and REQ-016..REQ-019.
REQ-030 SHALL, without MDU_DIV_EN, treat DIV/DIVU as no-ops (no busy, HI/LO unchanged) and contain no divider logic; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: MULT srcA=0xFFFFFFFE (-2), srcB=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 SHALL cover: DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 200/7 -> LO=28, HI=4.
REQ-033 SHALL cover: DIVU 200/0 after MTHI 0x11, MTLO 0x22 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-034 SHALL cover: start MULT 200*200, then start=1 with MDop=MTLO srcA=5 during busy -> ignored; LO=40000, HI=0 after 5 cycles.
REQ-035 SHALL cover: DIV in progress, reset low for 1 ns at busy cycle 4 -> busy=0, HI=LO=0 immediately and after release.
REQ-036 SHALL cover: build without MDU_DIV_EN, DIV 10/2 -> busy stays 0, HI/LO unchanged.
